// File: rtl/tmds_dec.sv
// TMDS lane receive decoder: hunts for control-token alignment, then decodes 10-bit symbols to data/control.
// Two-stage pipeline (aligned word, then decoded outputs); no backpressure, one symbol per pixel clock.
module tmds_dec #(
  parameter int LOCK_CNT       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] sym_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int TMR_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam int CNT_W   = (LOCK_CNT > 2) ? $clog2(LOCK_CNT) : 1;

  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(LOCK_CNT - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [3:0]       offset, offset_nxt;
  logic             stale, stale_nxt;

  logic [9:0]  prev;
  logic [19:0] win;
  logic [9:0]  q;
  logic [9:0]  q1;
  logic        is_ctrl;
  logic        tok_ok;
  logic [1:0]  tok_val;
  logic [7:0]  t;
  logic [7:0]  dec;

  // Bit 0 of prev is the earliest bit on the wire, so offset slides the word later in time.
  assign win = {sym_i, prev};
  assign q   = 10'(win >> offset);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev <= '0;
      q1   <= '0;
    end else begin
      prev <= sym_i;
      q1   <= q;
    end
  end

  always_comb begin
    is_ctrl = 1'b1;
    tok_val = 2'b00;
    case (q1)
      TOK_00:  tok_val = 2'b00;
      TOK_01:  tok_val = 2'b01;
      TOK_10:  tok_val = 2'b10;
      TOK_11:  tok_val = 2'b11;
      default: is_ctrl = 1'b0;
    endcase
  end

  always_comb begin
    t      = q1[9] ? ~q1[7:0] : q1[7:0];
    dec    = '0;
    dec[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = q1[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  // The word right after an offset step was sliced at the old offset; it must not count toward lock.
  assign tok_ok = is_ctrl & ~stale;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    tmr_nxt    = tmr;
    offset_nxt = offset;
    stale_nxt  = 1'b0;
    case (state)
      SEARCH: begin
        tmr_nxt = tmr + 1'b1;
        cnt_nxt = tok_ok ? cnt + 1'b1 : '0;
        if (tok_ok && (cnt == CNT_LAST)) begin
          state_nxt = LOCKED;
          tmr_nxt   = '0;
          cnt_nxt   = '0;
        end else if (tmr == SEARCH_LAST) begin
          offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          tmr_nxt    = '0;
          cnt_nxt    = '0;
          stale_nxt  = 1'b1;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          tmr_nxt = '0;
        end else if (tmr == LOSS_LAST) begin
          state_nxt = SEARCH;
          tmr_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      default: begin
        state_nxt = SEARCH;
        tmr_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= SEARCH;
      cnt    <= '0;
      tmr    <= '0;
      offset <= '0;
      stale  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tmr    <= tmr_nxt;
      offset <= offset_nxt;
      stale  <= stale_nxt;
    end
  end

  // de uses the next state so it can never be high in a cycle where locked_o is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o <= '0;
      ctrl_o <= '0;
      de_o   <= 1'b0;
    end else begin
      de_o <= (state_nxt == LOCKED) & ~is_ctrl;
      if (is_ctrl) begin
        ctrl_o <= tok_val;
      end else begin
        data_o <= dec;
      end
    end
  end

  assign locked_o = (state == LOCKED);
  assign offset_o = offset;

endmodule

// File: tb/tb_tmds_dec.sv
// Directed bench for tmds_dec: table of single-symbol decodes plus lock, loss, wrap and reset sequences.
module tb_tmds_dec;

  logic       clk;
  logic       rst_n;
  logic [9:0] sym;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;
  logic       de_o;
  logic       locked_o;
  logic [3:0] offset_o;

  tmds_dec dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sym_i    (sym),
    .data_o   (data_o),
    .ctrl_o   (ctrl_o),
    .de_o     (de_o),
    .locked_o (locked_o),
    .offset_o (offset_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] TOK00  = 10'b1101010100;
  localparam logic [9:0] TOK10  = 10'b0101010100;
  localparam logic [9:0] DAT00  = 10'b0100000000;
  localparam int         NBURST = 300;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } vec_t;

  vec_t       tbl[9];
  int         total = 0;
  int         bad = 0;
  int         rd = 0;
  logic [7:0] src[NBURST];
  logic [9:0] enc_sym[NBURST];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input int max, output int cyc);
    cyc = 0;
    while (!locked_o && cyc < max) begin
      tick(1);
      cyc++;
    end
  endtask

  // Transmit-side 8b/10b TMDS data encoder with running disparity in rd.
  task automatic tmds_enc(input logic [7:0] d, output logic [9:0] s);
    logic [8:0] qm;
    int n1d, n1q, n0q;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (rd == 0 || n1q == n0q) begin
      s[9]   = ~qm[8];
      s[8]   = qm[8];
      s[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      if (qm[8] == 1'b0) rd = rd + n0q - n1q;
      else rd = rd + n1q - n0q;
    end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
      s[9]   = 1'b1;
      s[8]   = qm[8];
      s[7:0] = ~qm[7:0];
      rd = rd + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      s[9]   = 1'b0;
      s[8]   = qm[8];
      s[7:0] = qm[7:0];
      rd = rd - 2 * int'(~qm[8]) + n1q - n0q;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic [9:0] tok;
    logic [9:0] rot;

    // Expected values follow from the decode rule; data/ctrl hold across the other kind of symbol.
    tbl[0] = '{sym: 10'b0100000000, data: 8'h00, ctrl: 2'b00, de: 1'b1};
    tbl[1] = '{sym: 10'b1011111111, data: 8'hFE, ctrl: 2'b00, de: 1'b1};
    tbl[2] = '{sym: 10'b0010101011, data: 8'hFE, ctrl: 2'b01, de: 1'b0};
    tbl[3] = '{sym: 10'b0101010100, data: 8'hFE, ctrl: 2'b10, de: 1'b0};
    tbl[4] = '{sym: 10'b1010101011, data: 8'hFE, ctrl: 2'b11, de: 1'b0};
    tbl[5] = '{sym: 10'b0111111111, data: 8'h01, ctrl: 2'b11, de: 1'b1};
    tbl[6] = '{sym: 10'b1100001111, data: 8'h10, ctrl: 2'b11, de: 1'b1};
    tbl[7] = '{sym: 10'b1101010101, data: 8'hFE, ctrl: 2'b11, de: 1'b1};
    tbl[8] = '{sym: 10'b1101010100, data: 8'hFE, ctrl: 2'b00, de: 1'b0};

    for (int i = 0; i < NBURST; i++) begin
      src[i] = 8'($urandom_range(0, 255));
      tmds_enc(src[i], enc_sym[i]);
    end

    rst_n = 1'b0;
    sym   = TOK00;
    tick(2);
    chk("reset data", int'(data_o), 0);
    chk("reset ctrl", int'(ctrl_o), 0);
    chk("reset de", int'(de_o), 0);
    chk("reset locked", int'(locked_o), 0);
    chk("reset offset", int'(offset_o), 0);

    // Aligned tokens at offset 0.
    rst_n = 1'b1;
    wait_lock(11, cyc);
    chk_range("lock time offset0", cyc, 1, 10);
    chk("lock offset0", int'(offset_o), 0);
    chk("lock ctrl00", int'(ctrl_o), 0);
    chk("lock de", int'(de_o), 0);

    // Offset 0 takes the word from prev, so each symbol shows on the outputs 3 edges after it is driven.
    for (int i = 0; i < 9; i++) begin
      sym = tbl[i].sym;
      tick(3);
      chk($sformatf("vec%0d data", i), int'(data_o), int'(tbl[i].data));
      chk($sformatf("vec%0d ctrl", i), int'(ctrl_o), int'(tbl[i].ctrl));
      chk($sformatf("vec%0d de", i), int'(de_o), int'(tbl[i].de));
      chk($sformatf("vec%0d locked", i), int'(locked_o), 1);
    end

    for (int k = 0; k < NBURST + 3; k++) begin
      if (k >= 3) begin
        chk($sformatf("burst%0d data", k - 3), int'(data_o), int'(src[k-3]));
        chk($sformatf("burst%0d de", k - 3), int'(de_o), 1);
      end
      sym = (k < NBURST) ? enc_sym[k] : TOK00;
      tick(1);
    end
    tick(5);
    chk("post burst locked", int'(locked_o), 1);

    // Loss of lock: 8192 data cycles at stage 1, the first arriving two edges after the switch.
    sym = DAT00;
    tick(LOSS_CYCLES_BEFORE_DROP());
    chk("loss still locked", int'(locked_o), 1);
    chk("loss de before drop", int'(de_o), 1);
    tick(1);
    chk("loss locked", int'(locked_o), 0);
    chk("loss de", int'(de_o), 0);
    chk("loss offset kept", int'(offset_o), 0);
    tick(5);
    chk("loss de stays 0", int'(de_o), 0);

    // Async reset while locked and carrying data.
    sym = TOK00;
    do_reset();
    wait_lock(11, cyc);
    chk_range("relock time", cyc, 1, 10);
    sym = DAT00;
    tick(4);
    chk("pre-reset de", int'(de_o), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async data", int'(data_o), 0);
    chk("async de", int'(de_o), 0);
    chk("async locked", int'(locked_o), 0);
    chk("async offset", int'(offset_o), 0);
    chk("async ctrl", int'(ctrl_o), 0);
    sym = TOK00;
    tick(2);
    rst_n = 1'b1;
    wait_lock(11, cyc);
    chk_range("lock after async reset", cyc, 1, 10);

    // Repeated token framed from bit 3: every word is the same rotation.
    tok = TOK10;
    rot = {tok[6:0], tok[9:7]};
    sym = rot;
    do_reset();
    wait_lock(3093, cyc);
    chk_range("lock time offset3", cyc, 3072, 3092);
    chk("lock offset3", int'(offset_o), 3);
    chk("lock ctrl10", int'(ctrl_o), 2);
    chk("lock offset3 de", int'(de_o), 0);

    // No tokens at all: offset steps every 1024 cycles and wraps after 9.
    sym = 10'b0000000000;
    do_reset();
    tick(512);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("wrap offset step%0d", k), int'(offset_o), k % 10);
      chk($sformatf("wrap locked step%0d", k), int'(locked_o), 0);
      tick(1024);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int LOSS_CYCLES_BEFORE_DROP();
    return 8193;
  endfunction

endmodule
